// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL bring-up sequencer with lock qualification, retry and lock-loss tracking
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 1024,
  parameter int RETRY_LIMIT   = 3,
  parameter int LOSS_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic                  sys_reset_n,
  output logic                  locked,
  output logic                  fail,
  output logic [LOSS_WIDTH-1:0] loss_count
);
  localparam int MAX_A   = RESET_CYCLES > LOCK_TIMEOUT ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = MAX_A > STABLE_CYCLES ? MAX_A : STABLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC);
  localparam int RW      = $clog2(RETRY_LIMIT + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RT_MAX   = RW'(RETRY_LIMIT);
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [LOSS_WIDTH-1:0] loss_d;
  logic lock_m, lock_s;
  // two-flop synchronizer bringing the raw PLL lock into the reference clock domain
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {lock_s, lock_m} <= 2'b00;
    else {lock_s, lock_m} <= {lock_m, pll_lock};
  // state, shared cycle counter, retry count and lock-loss count registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= RESET_PLL;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_count <= loss_d;
    end
  // next-state logic; lock events take priority over counter expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_count;
    unique case (state_q)
      RESET_PLL: if (cnt_q == RST_LAST) begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      WAIT_LOCK: if (lock_s) begin
        state_d = STABLE;
        cnt_d   = '0;
      end else if (cnt_q == TO_LAST) begin
        retry_d = retry_q + 1'b1;
        state_d = retry_d == RT_MAX ? FAIL : RESET_PLL;
        cnt_d   = '0;
      end
      STABLE: if (!lock_s) begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end else if (cnt_q == ST_LAST) begin
        state_d = RUN;
        retry_d = '0;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = RESET_PLL;
          loss_d  = &loss_count ? loss_count : loss_count + 1'b1;
        end
      end
      FAIL: cnt_d = '0;
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end
  assign pll_reset   = state_q == RESET_PLL || state_q == FAIL;
  assign sys_reset_n = state_q == RUN;
  assign locked      = state_q == RUN;
  assign fail        = state_q == FAIL;
endmodule
